// File: rtl/verify_pkg.sv
// Shared constants for the Saber constant-time region comparator.
// State encoding, default widths and the fixed latency overhead live here so the
// comparator and any controller that schedules around it agree on them.
package verify_pkg;

  // Default widths: 64-bit words, 512-word memory, 10-bit last-word offset.
  localparam int unsigned VERIFY_DW = 64;
  localparam int unsigned VERIFY_AW = 9;
  localparam int unsigned VERIFY_LW = 10;

  // Cycles beyond the two-per-word fetch phase: one TAIL cycle and the entry into DONE.
  localparam int unsigned VERIFY_FIXED_OVERHEAD = 2;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StF0   = 3'd1;
  localparam state_t StF1   = 3'd2;
  localparam state_t StTail = 3'd3;
  localparam state_t StDone = 3'd7;

  // Cycles from the start-sampling edge to done for a given last-word offset.
  function automatic int unsigned verify_latency(input int unsigned last_off);
    return 2 * (last_off + 1) + VERIFY_FIXED_OVERHEAD;
  endfunction

endpackage

// File: rtl/verify_cmp.sv
// Constant-time comparator: streams two equal-length regions through one read
// port, OR-accumulates their XOR and counts differing word pairs. Latency depends
// only on ilen, never on the data.
// Optional feature macro: VERIFY_LASTMASK_EN adds last_mask, which restricts the
// final word comparison to the masked bits.
module verify_cmp
  import verify_pkg::*;
#(
  parameter int unsigned DW = VERIFY_DW,
  parameter int unsigned AW = VERIFY_AW,
  parameter int unsigned LW = VERIFY_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] ilen,
  input  logic [AW-1:0] base0,
  input  logic [AW-1:0] base1,
  input  logic [DW-1:0] din,
`ifdef VERIFY_LASTMASK_EN
  input  logic [DW-1:0] last_mask,
`endif
  output logic [AW-1:0] rd_address,
  output logic          rd_en,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [LW:0]   mismatch_cnt
);

  state_t        r_state;
  state_t        w_state_d;
  logic [LW-1:0] r_ilen;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] w_cnt_d;
  logic [AW-1:0] r_base0;
  logic [AW-1:0] r_base1;
  logic [DW-1:0] r_d0;
  logic [DW-1:0] w_d0_d;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] w_acc_d;
  logic          r_first;
  logic          w_first_d;
  logic          r_equal;
  logic          w_equal_d;
  logic [LW:0]   r_mcnt;
  logic [LW:0]   w_mcnt_d;
  logic          w_accept;
  logic [AW-1:0] w_off;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_diff;
  logic          w_diff_nz;

  // A new request is only taken while idle or parked in DONE.
  assign w_accept = start && ((r_state == StIdle) || (r_state == StDone));

  // Offset wraps modulo 2^AW; ilen may exceed the memory size.
  assign w_off = r_cnt[AW-1:0];

`ifdef VERIFY_LASTMASK_EN
  logic [DW-1:0] r_last_mask;

  // Mask captured with the request so it stays stable for the whole compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_mask <= '0;
    end else if (w_accept) begin
      r_last_mask <= last_mask;
    end
  end

  assign w_mask = (r_state == StTail) ? r_last_mask : '1;
`else
  assign w_mask = '1;
`endif

  // Pair difference: d0 holds the region-0 word, din the matching region-1 word.
  always_comb begin
    w_diff    = (r_d0 ^ din) & w_mask;
    w_diff_nz = |w_diff;
  end

  // Read port and status outputs decoded from the current state.
  always_comb begin
    rd_address = '0;
    rd_en      = 1'b0;
    case (r_state)
      StF0: begin
        rd_address = r_base0 + w_off;
        rd_en      = 1'b1;
      end
      StF1: begin
        rd_address = r_base1 + w_off;
        rd_en      = 1'b1;
      end
      default: begin
        rd_address = '0;
        rd_en      = 1'b0;
      end
    endcase
    busy         = (r_state == StF0) || (r_state == StF1) || (r_state == StTail);
    done         = (r_state == StDone);
    equal        = r_equal;
    mismatch_cnt = r_mcnt;
  end

  // Next-state and datapath updates; no early exit, so every word pair costs two cycles.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_d0_d    = r_d0;
    w_acc_d   = r_acc;
    w_first_d = r_first;
    w_equal_d = r_equal;
    w_mcnt_d  = r_mcnt;
    case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
          w_state_d = StF0;
          w_cnt_d   = '0;
          w_acc_d   = '0;
          w_first_d = 1'b1;
          w_equal_d = 1'b0;
          w_mcnt_d  = '0;
        end
      end
      StF0: begin
        // din now carries region-1 word cnt-1; nothing to retire on the first word.
        if (!r_first) begin
          w_acc_d  = r_acc | w_diff;
          w_mcnt_d = r_mcnt + (LW + 1)'(w_diff_nz);
        end
        w_first_d = 1'b0;
        w_state_d = StF1;
      end
      StF1: begin
        w_d0_d = din;
        if (r_cnt == r_ilen) begin
          w_state_d = StTail;
        end else begin
          w_cnt_d   = r_cnt + LW'(1);
          w_state_d = StF0;
        end
      end
      StTail: begin
        w_acc_d   = r_acc | w_diff;
        w_mcnt_d  = r_mcnt + (LW + 1)'(w_diff_nz);
        w_equal_d = ((r_acc | w_diff) == '0);
        w_state_d = StDone;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any compare and forces the fail-safe result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_ilen  <= '0;
      r_cnt   <= '0;
      r_base0 <= '0;
      r_base1 <= '0;
      r_d0    <= '0;
      r_acc   <= '0;
      r_first <= 1'b0;
      r_equal <= 1'b0;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_d0    <= w_d0_d;
      r_acc   <= w_acc_d;
      r_first <= w_first_d;
      r_equal <= w_equal_d;
      r_mcnt  <= w_mcnt_d;
      if (w_accept) begin
        r_ilen  <= ilen;
        r_base0 <= base0;
        r_base1 <= base1;
      end
    end
  end

endmodule

// File: tb/tb_verify_cmp.sv
// Self-checking bench for verify_cmp: synchronous-read memory model, read-address
// monitor and a word-level reference model of the region comparison.
module tb_verify_cmp;

  localparam int unsigned MemWords = 512;
  localparam int unsigned Budget   = 4000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  ilen;
  logic [8:0]  base0;
  logic [8:0]  base1;
  logic [63:0] din;
  logic [8:0]  rd_address;
  logic        rd_en;
  logic        busy;
  logic        done;
  logic        equal;
  logic [10:0] mismatch_cnt;
`ifdef VERIFY_LASTMASK_EN
  logic [63:0] last_mask;
`endif

  logic [63:0] mem [MemWords];
  int unsigned addr_q[$];
  int          n_checks;
  int          n_fail;

  verify_cmp #(
    .DW(64),
    .AW(9),
    .LW(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ilen        (ilen),
    .base0       (base0),
    .base1       (base1),
    .din         (din),
`ifdef VERIFY_LASTMASK_EN
    .last_mask   (last_mask),
`endif
    .rd_address  (rd_address),
    .rd_en       (rd_en),
    .busy        (busy),
    .done        (done),
    .equal       (equal),
    .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) din <= mem[rd_address];
  end

  // Log every issued read address.
  always @(negedge clk) begin
    if (rd_en) addr_q.push_back(int'(rd_address));
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: count differing word pairs over the two (wrapping) regions.
  task automatic model(input int b0, input int b1, input int len,
                       output bit exp_eq, output int exp_cnt);
    logic [63:0] d;
    exp_cnt = 0;
    for (int i = 0; i <= len; i++) begin
      d = mem[(b0 + i) % MemWords] ^ mem[(b1 + i) % MemWords];
`ifdef VERIFY_LASTMASK_EN
      if (i == len) d = d & last_mask;
`endif
      if (d != 64'd0) exp_cnt++;
    end
    exp_eq = (exp_cnt == 0);
  endtask

  // Index of first wrong read address, -2 for a wrong read count, -1 if all match.
  function automatic int addr_bad(input int b0, input int b1, input int len);
    if (addr_q.size() != 2 * (len + 1)) return -2;
    for (int i = 0; i <= len; i++) begin
      if (addr_q[2*i] != (b0 + i) % MemWords) return 2 * i;
      if (addr_q[2*i+1] != (b1 + i) % MemWords) return 2 * i + 1;
    end
    return -1;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < MemWords; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic copy_region(input int b0, input int b1, input int len);
    for (int i = 0; i <= len; i++) mem[(b1 + i) % MemWords] = mem[(b0 + i) % MemWords];
  endtask

  // Issue one request and return cycles from the start-sampling edge to done.
  task automatic run_op(input int b0, input int b1, input int len, output int lat);
    @(posedge clk); #1;
    base0 = 9'(b0);
    base1 = 9'(b1);
    ilen  = 10'(len);
    start = 1'b1;
    addr_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < Budget) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 6;
    if (rd_address !== 9'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", rd_address); end
    if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    if (equal !== 1'b0) begin n_fail++; $display("FAIL reset_equal: got %b want 0", equal); end
    if (mismatch_cnt !== 11'd0) begin
      n_fail++; $display("FAIL reset_mcnt: got %0d want 0", mismatch_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_equal();
    int lat;
    int bad;
    fill_random();
    copy_region(0, 'h100, 3);
    run_op(0, 'h100, 3, lat);
    bad = addr_bad(0, 'h100, 3);
    n_checks += 5;
    if (lat !== 10) begin n_fail++; $display("FAIL eq_latency: got %0d want 10", lat); end
    if (equal !== 1'b1) begin n_fail++; $display("FAIL eq_equal: got %b want 1", equal); end
    if (mismatch_cnt !== 11'd0) begin n_fail++; $display("FAIL eq_mcnt: got %0d want 0", mismatch_cnt); end
    if (bad != -1) begin n_fail++; $display("FAIL eq_addr: bad index %0d want -1", bad); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL eq_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_single_mismatch();
    int lat;
    mem['h102] = mem[2] ^ (64'h1 << 63);
    run_op(0, 'h100, 3, lat);
    n_checks += 3;
    if (lat !== 10) begin n_fail++; $display("FAIL mm_latency: got %0d want 10", lat); end
    if (equal !== 1'b0) begin n_fail++; $display("FAIL mm_equal: got %b want 0", equal); end
    if (mismatch_cnt !== 11'd1) begin n_fail++; $display("FAIL mm_mcnt: got %0d want 1", mismatch_cnt); end
  endtask

  task automatic test_const_time();
    int lat;
    bit exp_eq;
    int exp_cnt;
    for (int k = 0; k < 3; k++) begin
      fill_random();
      copy_region(0, 'h100, 255);
      if (k == 0) mem['h100] = mem['h100] ^ 64'h10;
      if (k == 1) mem['h1FF] = mem['h1FF] ^ 64'h8000;
      model(0, 'h100, 255, exp_eq, exp_cnt);
      run_op(0, 'h100, 255, lat);
      n_checks += 3;
      if (lat !== 514) begin n_fail++; $display("FAIL ct_latency[%0d]: got %0d want 514", k, lat); end
      if (equal !== exp_eq) begin n_fail++; $display("FAIL ct_equal[%0d]: got %b want %b", k, equal, exp_eq); end
      if (int'(mismatch_cnt) != exp_cnt) begin
        n_fail++; $display("FAIL ct_mcnt[%0d]: got %0d want %0d", k, mismatch_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_boundary();
    int lat;
    int bad;
    bit exp_eq;
    int exp_cnt;
    fill_random();
    mem['h1FF] = mem[0];
    run_op(0, 'h1FF, 0, lat);
    bad = addr_bad(0, 'h1FF, 0);
    n_checks += 3;
    if (lat !== 4) begin n_fail++; $display("FAIL b0_latency: got %0d want 4", lat); end
    if (bad != -1) begin n_fail++; $display("FAIL b0_addr: bad index %0d want -1", bad); end
    if (equal !== 1'b1) begin n_fail++; $display("FAIL b0_equal: got %b want 1", equal); end

    copy_region('h1FE, 'h080, 2);
    mem['h082] = mem['h082] ^ 64'h1;
    run_op('h1FE, 'h080, 2, lat);
    bad = addr_bad('h1FE, 'h080, 2);
    n_checks += 4;
    if (lat !== 8) begin n_fail++; $display("FAIL wrap_latency: got %0d want 8", lat); end
    if (bad != -1) begin n_fail++; $display("FAIL wrap_addr: bad index %0d want -1", bad); end
    if (equal !== 1'b0) begin n_fail++; $display("FAIL wrap_equal: got %b want 0", equal); end
    if (mismatch_cnt !== 11'd1) begin n_fail++; $display("FAIL wrap_mcnt: got %0d want 1", mismatch_cnt); end

    // Offset beyond memory size: regions wrap past themselves.
    model('h010, 'h020, 700, exp_eq, exp_cnt);
    run_op('h010, 'h020, 700, lat);
    bad = addr_bad('h010, 'h020, 700);
    n_checks += 3;
    if (lat !== 1404) begin n_fail++; $display("FAIL long_latency: got %0d want 1404", lat); end
    if (bad != -1) begin n_fail++; $display("FAIL long_addr: bad index %0d want -1", bad); end
    if (int'(mismatch_cnt) != exp_cnt) begin
      n_fail++; $display("FAIL long_mcnt: got %0d want %0d", mismatch_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    int lat;
    int bad;
    int b0;
    int b1;
    int len;
    int flips;
    bit exp_eq;
    int exp_cnt;
    for (int it = 0; it < 10; it++) begin
      fill_random();
      b0  = int'($urandom_range(0, MemWords - 1));
      b1  = int'($urandom_range(0, MemWords - 1));
      len = int'($urandom_range(0, 40));
      copy_region(b0, b1, len);
      flips = int'($urandom_range(0, 3));
      for (int f = 0; f < flips; f++) begin
        mem[(b1 + int'($urandom_range(0, len))) % MemWords] ^= (64'h1 << $urandom_range(0, 63));
      end
      model(b0, b1, len, exp_eq, exp_cnt);
      run_op(b0, b1, len, lat);
      bad = addr_bad(b0, b1, len);
      n_checks += 4;
      if (lat != 2 * (len + 1) + 2) begin
        n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, lat, 2 * (len + 1) + 2);
      end
      if (bad != -1) begin n_fail++; $display("FAIL rnd_addr[%0d]: bad index %0d want -1", it, bad); end
      if (equal !== exp_eq) begin n_fail++; $display("FAIL rnd_equal[%0d]: got %b want %b", it, equal, exp_eq); end
      if (int'(mismatch_cnt) != exp_cnt) begin
        n_fail++; $display("FAIL rnd_mcnt[%0d]: got %0d want %0d", it, mismatch_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_handshake();
    int n;
    int bad;
    int lat;
    bit saw_done;
    fill_random();
    copy_region(0, 'h100, 3);
    // Start pulsed while in F1 must not disturb the running compare.
    @(posedge clk); #1;
    base0 = 9'h000; base1 = 9'h100; ilen = 10'd3; start = 1'b1;
    addr_q.delete();
    @(posedge clk); #1;
    start = 1'b0; n = 1;
    @(posedge clk); #1;
    n = 2;
    start = 1'b1; base0 = 9'h055; ilen = 10'd0;
    @(posedge clk); #1;
    start = 1'b0; n = 3;
    while (!done && n < Budget) begin
      @(posedge clk); #1;
      n++;
    end
    bad = addr_bad(0, 'h100, 3);
    n_checks += 3;
    if (n !== 10) begin n_fail++; $display("FAIL hs_ignore_latency: got %0d want 10", n); end
    if (bad != -1) begin n_fail++; $display("FAIL hs_ignore_addr: bad index %0d want -1", bad); end
    if (equal !== 1'b1) begin n_fail++; $display("FAIL hs_ignore_equal: got %b want 1", equal); end

    // Restart from DONE clears equal on the next cycle.
    mem['h101] = mem[1] ^ 64'h4;
    base0 = 9'h000; ilen = 10'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks += 3;
    if (equal !== 1'b0) begin n_fail++; $display("FAIL hs_restart_equal: got %b want 0", equal); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL hs_restart_done: got %b want 0", done); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_restart_busy: got %b want 1", busy); end
    n = 1;
    while (!done && n < Budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks += 1;
    if (mismatch_cnt !== 11'd1) begin n_fail++; $display("FAIL hs_second_mcnt: got %0d want 1", mismatch_cnt); end

    // Restart again: the count from the previous run clears on the next cycle.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks += 1;
    if (mismatch_cnt !== 11'd0) begin n_fail++; $display("FAIL hs_restart_mcnt: got %0d want 0", mismatch_cnt); end
    run_op(0, 'h100, 3, lat);

    // Reset in F0 aborts with no done pulse.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks += 4;
    if (done !== 1'b0) begin n_fail++; $display("FAIL hs_rst_done: got %b want 0", done); end
    if (equal !== 1'b0) begin n_fail++; $display("FAIL hs_rst_equal: got %b want 0", equal); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_rst_busy: got %b want 0", busy); end
    if (rd_en !== 1'b0) begin n_fail++; $display("FAIL hs_rst_rd_en: got %b want 0", rd_en); end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    n_checks += 1;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL hs_rst_no_done: got %b want 0", saw_done); end
  endtask

`ifdef VERIFY_LASTMASK_EN
  task automatic test_lastmask();
    int lat;
    fill_random();
    copy_region(0, 'h100, 3);
    last_mask = 64'h0000_0000_FFFF_FFFF;
    mem['h103] = mem[3] ^ (64'h1 << 40);
    run_op(0, 'h100, 3, lat);
    n_checks += 2;
    if (equal !== 1'b1) begin n_fail++; $display("FAIL lm_hi_equal: got %b want 1", equal); end
    if (mismatch_cnt !== 11'd0) begin n_fail++; $display("FAIL lm_hi_mcnt: got %0d want 0", mismatch_cnt); end
    mem['h103] = mem[3] ^ (64'h1 << 5);
    run_op(0, 'h100, 3, lat);
    n_checks += 2;
    if (equal !== 1'b0) begin n_fail++; $display("FAIL lm_lo_equal: got %b want 0", equal); end
    if (mismatch_cnt !== 11'd1) begin n_fail++; $display("FAIL lm_lo_mcnt: got %0d want 1", mismatch_cnt); end
    last_mask = '1;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    ilen     = '0;
    base0    = '0;
    base1    = '0;
    din      = '0;
`ifdef VERIFY_LASTMASK_EN
    last_mask = '1;
`endif
    test_reset();
    test_equal();
    test_single_mismatch();
    test_const_time();
    test_boundary();
    test_random();
    test_handshake();
`ifdef VERIFY_LASTMASK_EN
    test_lastmask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
